// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_REG_W    = 3;
  localparam int unsigned DEF_WB_LAT   = 2;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Pipeline control bundle driven toward PC, IF/ID and ID/EX registers.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};

  // Control bundle that corresponds to a given controller decision.
  function automatic ctrl_t ctrl_for(input state_e st);
    case (st)
      ST_STALL: ctrl_for = CTRL_STALL;
      ST_FLUSH: ctrl_for = CTRL_FLUSH;
      default:  ctrl_for = CTRL_RUN;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  // Increment on enable until the counter reaches its maximum.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (en_i && (count_o != '1)) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard and flush sequencer for the 5-stage pipeline.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned REG_W    = DEF_REG_W,
  parameter int unsigned WB_LAT   = DEF_WB_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                id_valid_i,
  input  logic [REG_W-1:0]    id_rs_i,
  input  logic [REG_W-1:0]    id_rt_i,
  input  logic                id_uses_rs_i,
  input  logic                id_uses_rt_i,
  input  logic [REG_W-1:0]    id_rd_i,
  input  logic                id_reg_write_i,
  input  logic                br_taken_i,
  output logic                pc_write_o,
  output logic                ifid_write_o,
  output logic                ifid_flush_o,
  output logic                idex_flush_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    stall_cycles_o,
  output logic [CNT_W-1:0]    flush_count_o
);

  localparam int unsigned LAT_W = $clog2(WB_LAT + 1);

  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                issue;
  logic                stall_en;
  logic                flush_en;
  ctrl_t               ctrl;
  state_e              state;
  state_e              next_state;

  // A source only hazards when it is really read and its producer is still in flight.
  assign hazard = id_valid_i &
                  ((id_uses_rs_i & busy[id_rs_i]) |
                   (id_uses_rt_i & busy[id_rt_i]));

  // Decision per cycle: taken branch beats hazard beats normal issue.
  always_comb begin
    ctrl       = ctrl_for(ST_RUN);
    next_state = ST_RUN;
    stall_en   = 1'b0;
    flush_en   = 1'b0;
    issue      = 1'b0;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (br_taken_i) begin
      ctrl       = ctrl_for(ST_FLUSH);
      next_state = ST_FLUSH;
      flush_en   = 1'b1;
    end else if (hazard) begin
      ctrl       = ctrl_for(ST_STALL);
      next_state = ST_STALL;
      stall_en   = 1'b1;
    end else begin
      issue = id_valid_i & id_reg_write_i & (id_rd_i != '0);
    end
  end

  assign pc_write_o   = ctrl.pc_write;
  assign ifid_write_o = ctrl.ifid_write;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_flush_o = ctrl.idex_flush;

  // Informational state register tracking the last decision.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  assign state_o = state;

  // Per-register countdown of cycles until the pending result is readable in ID.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign busy[r] = 1'b0;
    end else begin : g_trk
      logic [LAT_W-1:0] cnt;

      // Reload on issue (including WAW), otherwise drain toward zero every cycle.
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (issue && (id_rd_i == REG_W'(r))) begin
          cnt <= LAT_W'(WB_LAT);
        end else if (cnt != '0) begin
          cnt <= cnt - LAT_W'(1);
        end
      end

      assign busy[r] = (cnt != '0);
    end
  end

  assign busy_o = busy;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .en_i    (stall_en),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .en_i    (flush_en),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; a narrow-statistics twin covers saturation.
module tb_hazard_scoreboard;

  localparam logic [3:0] C_RST = 4'b0011;
  localparam logic [3:0] C_RUN = 4'b1100;
  localparam logic [3:0] C_STL = 4'b0001;
  localparam logic [3:0] C_FLS = 4'b1111;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_STL = 2'd1;
  localparam logic [1:0] S_FLS = 2'd2;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [7:0]  busy;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  id_rs = '0;
  logic [2:0]  id_rt = '0;
  logic        id_uses_rs = 1'b0;
  logic        id_uses_rt = 1'b0;
  logic [2:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        br_taken = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic [7:0]  busy;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_count;

  logic        s_pc, s_ifw, s_iff, s_idf;
  logic [7:0]  s_busy;
  logic [1:0]  s_state;
  logic [2:0]  s_stall, s_flush;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .br_taken_i     (br_taken),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_flush_o   (idex_flush),
    .busy_o         (busy),
    .state_o        (state),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );

  hazard_scoreboard #(.CNT_W(3)) sat_dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .br_taken_i     (br_taken),
    .pc_write_o     (s_pc),
    .ifid_write_o   (s_ifw),
    .ifid_flush_o   (s_iff),
    .idex_flush_o   (s_idf),
    .busy_o         (s_busy),
    .state_o        (s_state),
    .stall_cycles_o (s_stall),
    .flush_count_o  (s_flush)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] sat7(input logic [15:0] v);
    sat7 = (v > 16'd7) ? 16'd7 : v;
  endfunction

  // Monitor: pop one expectation per cycle and compare away from the rising edge.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctl", 16'({pc_write, ifid_write, ifid_flush, idex_flush}), 16'(e.ctl));
      check("busy", 16'(busy), 16'(e.busy));
      check("state", 16'(state), 16'(e.st));
      check("stall_cycles", stall_cycles, e.stall);
      check("flush_count", flush_count, e.flush);
      check("sat_stall", 16'(s_stall), sat7(e.stall));
      check("sat_flush", 16'(s_flush), sat7(e.flush));
    end
  end

  // Drive one cycle of inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic r, input logic v,
                     input logic [2:0] rs, input logic urs,
                     input logic [2:0] rt, input logic urt,
                     input logic [2:0] rd, input logic rw, input logic br,
                     input logic [3:0] ctl, input logic [7:0] bz, input logic [1:0] st,
                     input int stall, input int flush);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_n = r; id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; br_taken = br;
    e.ctl = ctl; e.busy = bz; e.st = st; e.stall = 16'(stall); e.flush = 16'(flush);
    exp_q.push_back(e);
  endtask

  initial begin
    int s;
    // reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 8'h00, S_RUN, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 8'h00, S_RUN, 0, 0);
    // producer r3, consumer rs=3 stalls two cycles
    cyc(1, 1, 0, 0, 0, 0, 3, 1, 0, C_RUN, 8'h00, S_RUN, 0, 0);
    cyc(1, 1, 3, 1, 0, 0, 0, 0, 0, C_STL, 8'h08, S_RUN, 0, 0);
    cyc(1, 1, 3, 1, 0, 0, 0, 0, 0, C_STL, 8'h08, S_STL, 1, 0);
    cyc(1, 1, 3, 1, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_STL, 2, 0);
    // r0 is never tracked
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, C_RUN, 8'h00, S_RUN, 2, 0);
    cyc(1, 1, 0, 1, 0, 1, 0, 0, 0, C_RUN, 8'h00, S_RUN, 2, 0);
    // hazard on rt=5 with taken branch: flush only, r6 not issued
    cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, C_RUN, 8'h00, S_RUN, 2, 0);
    cyc(1, 1, 0, 0, 5, 1, 6, 1, 1, C_FLS, 8'h20, S_RUN, 2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h20, S_FLS, 2, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_RUN, 2, 1);
    // WAW on r2 reloads the counter
    cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, C_RUN, 8'h00, S_RUN, 2, 1);
    cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, C_RUN, 8'h04, S_RUN, 2, 1);
    cyc(1, 1, 2, 1, 0, 0, 0, 0, 0, C_STL, 8'h04, S_RUN, 2, 1);
    cyc(1, 1, 2, 1, 0, 0, 0, 0, 0, C_STL, 8'h04, S_STL, 3, 1);
    cyc(1, 1, 2, 1, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_STL, 4, 1);
    // unused sources and invalid ID never stall
    cyc(1, 1, 0, 0, 0, 0, 4, 1, 0, C_RUN, 8'h00, S_RUN, 4, 1);
    cyc(1, 1, 4, 0, 4, 0, 0, 0, 0, C_RUN, 8'h10, S_RUN, 4, 1);
    cyc(1, 0, 4, 1, 4, 1, 0, 0, 0, C_RUN, 8'h10, S_RUN, 4, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_RUN, 4, 1);
    // self-dependent r1 instruction held in ID: issue, stall, stall, repeat
    s = 4;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 1, 0, 0, 1, 1, 0, C_RUN, 8'h00, (k == 0) ? S_RUN : S_STL, s, 1);
      cyc(1, 1, 1, 1, 0, 0, 1, 1, 0, C_STL, 8'h02, S_RUN, s, 1);
      s++;
      cyc(1, 1, 1, 1, 0, 0, 1, 1, 0, C_STL, 8'h02, S_STL, s, 1);
      s++;
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_STL, 10, 1);
    // consecutive taken branches
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FLS, 8'h00, (i == 0) ? S_RUN : S_FLS, 10, 1 + i);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_FLS, 10, 10);
    // reset during a stall, then issue immediately after release
    cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, C_RUN, 8'h00, S_RUN, 10, 10);
    cyc(1, 1, 7, 1, 0, 0, 0, 0, 0, C_STL, 8'h80, S_RUN, 10, 10);
    cyc(0, 1, 7, 1, 0, 0, 0, 0, 0, C_RST, 8'h00, S_RUN, 0, 0);
    cyc(1, 1, 7, 1, 0, 0, 7, 1, 0, C_RUN, 8'h00, S_RUN, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h80, S_RUN, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h80, S_RUN, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8'h00, S_RUN, 0, 0);
    repeat (3) @(posedge clk_i);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
